// File: rtl/addr_gen_pkg.sv
// Shared definitions for the burst address generator family.
// Holds the state encoding of the read-side generator and the default
// address width, so the planned write-side generator uses the same values.
package addr_gen_pkg;

  localparam int unsigned DEFAULT_WIDE = 23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addr_step_cmp.sv
// Address step and bound comparator.
// Adds the stride to the current address one bit wider than the address,
// so a carry out of the top bit can never wrap around, and flags whether
// the current address is the last one allowed by the inclusive end bound.
// Ports:
//   addr_i  current address
//   end_i   inclusive end address
//   step_i  stride (already forced non-zero by the caller)
//   nxt_o   addr_i + step_i, WIDE+1 bits
//   last_o  1 when no further address may be issued after addr_i
module addr_step_cmp
  import addr_gen_pkg::*;
#(
  parameter int unsigned WIDE   = DEFAULT_WIDE,
  parameter int unsigned STEP_W = 8
) (
  input  logic [WIDE-1:0]   addr_i,
  input  logic [WIDE-1:0]   end_i,
  input  logic [STEP_W-1:0] step_i,
  output logic [WIDE:0]     nxt_o,
  output logic              last_o
);

  assign nxt_o  = {1'b0, addr_i} + {{(WIDE + 1 - STEP_W){1'b0}}, step_i};
  // The second term covers start > end, which emits exactly one address.
  assign last_o = (nxt_o > {1'b0, end_i}) | (addr_i >= end_i);

endmodule

// File: rtl/burst_address_gen.sv
// Programmable burst address generator.
// Walks from a latched start address to an inclusive end address with a
// latched stride, handing each address to the memory read port through a
// valid/ready handshake. One-shot or continuous (wrap) operation, abort,
// burst-boundary marking and a completion pulse.
// Ports:
//   iCLK, iRST_N        clock, asynchronous active-low reset
//   iSTART / iSTOP      begin a sequence / abort to IDLE (iSTOP wins)
//   iSTART_ADDR, iEND_ADDR, iSTEP, iWRAP  configuration, sampled on iSTART
//   iREADY              consumer takes oADDRESS this cycle
//   oADDRESS, oVALID    address beat and its qualifier
//   oBURST_LAST         last beat of a BURST_LEN group or of the sequence
//   oWRAP_P, oDONE      one-cycle wrap / one-shot completion pulses
//   oBUSY               high while running
//   oCOUNT              beats accepted since the last start, saturating
module burst_address_gen
  import addr_gen_pkg::*;
#(
  parameter int unsigned WIDE      = DEFAULT_WIDE,
  parameter int unsigned STEP_W    = 8,
  parameter int unsigned BURST_LEN = 8
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iSTART,
  input  logic              iSTOP,
  input  logic [WIDE-1:0]   iSTART_ADDR,
  input  logic [WIDE-1:0]   iEND_ADDR,
  input  logic [STEP_W-1:0] iSTEP,
  input  logic              iWRAP,
  input  logic              iREADY,
  output logic [WIDE-1:0]   oADDRESS,
  output logic              oVALID,
  output logic              oBURST_LAST,
  output logic              oWRAP_P,
  output logic              oDONE,
  output logic              oBUSY,
  output logic [WIDE-1:0]   oCOUNT
);

  localparam int unsigned BEAT_W = $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE = {{(BEAT_W - 1){1'b0}}, 1'b1};
  localparam logic [WIDE-1:0]   CNT_ONE  = {{(WIDE - 1){1'b0}}, 1'b1};
  localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W - 1){1'b0}}, 1'b1};

  state_t              state_q;
  logic [WIDE-1:0]     addr_q;
  logic [WIDE-1:0]     start_q;
  logic [WIDE-1:0]     end_q;
  logic [STEP_W-1:0]   step_q;
  logic                wrap_mode_q;
  logic                valid_q;
  logic                busy_q;
  logic                wrap_p_q;
  logic                done_q;
  logic [WIDE-1:0]     count_q;
  logic [BEAT_W-1:0]   beat_q;

  logic [WIDE:0]       nxt_d;
  logic                last_d;
  logic                accept;

  addr_step_cmp #(
    .WIDE   (WIDE),
    .STEP_W (STEP_W)
  ) u_step_cmp (
    .addr_i (addr_q),
    .end_i  (end_q),
    .step_i (step_q),
    .nxt_o  (nxt_d),
    .last_o (last_d)
  );

  assign accept = valid_q & iREADY;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      start_q     <= '0;
      end_q       <= '0;
      step_q      <= '0;
      wrap_mode_q <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      wrap_p_q    <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
      beat_q      <= '0;
    end else begin
      wrap_p_q <= 1'b0;
      done_q   <= 1'b0;
      if (iSTOP) begin
        state_q <= ST_IDLE;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (iSTART) begin
              start_q     <= iSTART_ADDR;
              end_q       <= iEND_ADDR;
              step_q      <= (iSTEP == '0) ? STEP_ONE : iSTEP;
              wrap_mode_q <= iWRAP;
              addr_q      <= iSTART_ADDR;
              valid_q     <= 1'b1;
              busy_q      <= 1'b1;
              count_q     <= '0;
              beat_q      <= '0;
              state_q     <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (accept) begin
              if (count_q != '1) count_q <= count_q + CNT_ONE;
              beat_q <= beat_q + BEAT_ONE;
              if (last_d) begin
                if (wrap_mode_q) begin
                  addr_q   <= start_q;
                  wrap_p_q <= 1'b1;
                  beat_q   <= '0;
                end else begin
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
                end
              end else begin
                addr_q <= nxt_d[WIDE-1:0];
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign oADDRESS    = addr_q;
  assign oVALID      = valid_q;
  // Qualified by valid so the flag stays low in IDLE/DONE and after reset.
  assign oBURST_LAST = valid_q & ((beat_q == BEAT_MAX) | last_d);
  assign oWRAP_P     = wrap_p_q;
  assign oDONE       = done_q;
  assign oBUSY       = busy_q;
  assign oCOUNT      = count_q;

endmodule

// File: tb/tb_burst_address_gen.sv
module tb_burst_address_gen;

  localparam int WIDE   = 23;
  localparam int STEP_W = 8;
  localparam int BL     = 8;

  logic              iCLK;
  logic              iRST_N;
  logic              iSTART;
  logic              iSTOP;
  logic [WIDE-1:0]   iSTART_ADDR;
  logic [WIDE-1:0]   iEND_ADDR;
  logic [STEP_W-1:0] iSTEP;
  logic              iWRAP;
  logic              iREADY;
  logic [WIDE-1:0]   oADDRESS;
  logic              oVALID;
  logic              oBURST_LAST;
  logic              oWRAP_P;
  logic              oDONE;
  logic              oBUSY;
  logic [WIDE-1:0]   oCOUNT;

  burst_address_gen #(
    .WIDE      (WIDE),
    .STEP_W    (STEP_W),
    .BURST_LEN (BL)
  ) dut (
    .iCLK        (iCLK),
    .iRST_N      (iRST_N),
    .iSTART      (iSTART),
    .iSTOP       (iSTOP),
    .iSTART_ADDR (iSTART_ADDR),
    .iEND_ADDR   (iEND_ADDR),
    .iSTEP       (iSTEP),
    .iWRAP       (iWRAP),
    .iREADY      (iREADY),
    .oADDRESS    (oADDRESS),
    .oVALID      (oVALID),
    .oBURST_LAST (oBURST_LAST),
    .oWRAP_P     (oWRAP_P),
    .oDONE       (oDONE),
    .oBUSY       (oBUSY),
    .oCOUNT      (oCOUNT)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Observations gathered by the collector
  logic [WIDE-1:0] obs_addr[$];
  bit              obs_last[$];
  int              obs_wraps, obs_done, obs_unstable;
  bit              obs_timeout;

  // Reference model output
  logic [WIDE-1:0] exp_addr[$];
  bit              exp_last[$];
  int              exp_len;

  // The address list is every start + k*step that does not exceed end, but
  // always at least the start address itself.
  function automatic void build_model(input longint s, input longint e,
                                      input longint st, input bit wrap,
                                      input int n);
    longint seq[$];
    longint a;
    exp_addr.delete();
    exp_last.delete();
    if (st == 0) st = 1;
    a = s;
    seq.push_back(a);
    while (a < e && a + st <= e) begin
      a = a + st;
      seq.push_back(a);
    end
    exp_len = seq.size();
    if (!wrap) n = exp_len;
    for (int k = 0; k < n; k++) begin
      int j;
      longint v;
      j = k % exp_len;
      v = seq[j];
      exp_addr.push_back(v[WIDE-1:0]);
      exp_last.push_back((j % BL == BL - 1) || (j == exp_len - 1));
    end
  endfunction

  // Called at a falling edge; returns at the falling edge after the start edge.
  task automatic do_start(input longint s, input longint e, input int st, input bit w);
    iSTART_ADDR = s[WIDE-1:0];
    iEND_ADDR   = e[WIDE-1:0];
    iSTEP       = st[STEP_W-1:0];
    iWRAP       = w;
    iSTART      = 1'b1;
    @(negedge iCLK);
    iSTART      = 1'b0;
  endtask

  task automatic do_stop();
    iSTOP = 1'b1;
    @(negedge iCLK);
    iSTOP = 1'b0;
  endtask

  // Drives iREADY (0: always, 1: 1,0,0 pattern, 2: random), scrambles the
  // configuration inputs and stray iSTART pulses while running, and records
  // every accepted beat until oDONE or max_beats accepted.
  task automatic collect(input int max_beats, input int mode, input int max_cycles);
    int cyc = 0;
    bit r;
    bit stalled = 1'b0;
    bit stop_req = 1'b0;
    logic [WIDE-1:0] pa = '0;
    obs_addr.delete();
    obs_last.delete();
    obs_wraps = 0;
    obs_done = 0;
    obs_unstable = 0;
    obs_timeout = 1'b1;
    while (cyc < max_cycles) begin
      if (oWRAP_P) obs_wraps++;
      if (stalled && oADDRESS !== pa) obs_unstable++;
      if (oDONE) begin
        obs_done++;
        obs_timeout = 1'b0;
        break;
      end
      if (stop_req) begin
        obs_timeout = 1'b0;
        break;
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      iREADY      = r;
      iSTART_ADDR = WIDE'($urandom);
      iEND_ADDR   = WIDE'($urandom);
      iSTEP       = STEP_W'($urandom);
      iWRAP       = 1'($urandom_range(0, 1));
      iSTART      = (mode == 2) ? (oVALID & 1'($urandom_range(0, 1))) : 1'b0;
      if (oVALID && r) begin
        obs_addr.push_back(oADDRESS);
        obs_last.push_back(oBURST_LAST);
      end
      stalled = oVALID && !r;
      pa = oADDRESS;
      if (obs_addr.size() >= max_beats) stop_req = 1'b1;
      @(negedge iCLK);
      cyc++;
      if (stop_req) iREADY = 1'b0;
    end
    iSTART = 1'b0;
    iREADY = 1'b0;
  endtask

  task automatic test_reset();
    iRST_N = 1'b0;
    iSTART = 1'b0;
    iSTOP = 1'b0;
    iSTART_ADDR = '0;
    iEND_ADDR = '0;
    iSTEP = '0;
    iWRAP = 1'b0;
    iREADY = 1'b0;
    repeat (2) @(negedge iCLK);
    total_cnt++;
    if ({oADDRESS, oCOUNT} !== '0) $display("FAIL reset_addr_count: got %h/%h want 0/0", oADDRESS, oCOUNT);
    else pass_cnt++;
    total_cnt++;
    if ({oVALID, oBUSY, oBURST_LAST, oWRAP_P, oDONE} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {oVALID, oBUSY, oBURST_LAST, oWRAP_P, oDONE});
    else pass_cnt++;
    iRST_N = 1'b1;
    @(negedge iCLK);
  endtask

  task automatic test_oneshot();
    do_start(0, 9, 1, 0);
    total_cnt++;
    if ({oVALID, oBUSY} !== 2'b11 || oADDRESS !== 23'd0 || oCOUNT !== 23'd0)
      $display("FAIL oneshot_first_beat: got v%b b%b a%h c%h want v1 b1 a0 c0", oVALID, oBUSY, oADDRESS, oCOUNT);
    else pass_cnt++;
    collect(1000, 0, 100);
    build_model(0, 9, 1, 0, 0);
    total_cnt++;
    if (obs_addr.size() != exp_addr.size()) $display("FAIL oneshot_len: got %0d want %0d", obs_addr.size(), exp_addr.size());
    else pass_cnt++;
    for (int k = 0; k < exp_addr.size() && k < obs_addr.size(); k++) begin
      total_cnt++;
      if (obs_addr[k] !== exp_addr[k] || obs_last[k] !== exp_last[k])
        $display("FAIL oneshot_beat%0d: got %h/%b want %h/%b", k, obs_addr[k], obs_last[k], exp_addr[k], exp_last[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (obs_timeout || obs_done != 1) $display("FAIL oneshot_done: timeout %b done %0d want 0/1", obs_timeout, obs_done);
    else pass_cnt++;
    total_cnt++;
    if (oCOUNT !== 23'd10 || oADDRESS !== 23'd9 || oVALID !== 1'b0 || oBUSY !== 1'b0)
      $display("FAIL oneshot_final: got c%0d a%h v%b b%b want c10 a9 v0 b0", oCOUNT, oADDRESS, oVALID, oBUSY);
    else pass_cnt++;
    @(negedge iCLK);
    total_cnt++;
    if (oDONE !== 1'b0) $display("FAIL oneshot_done_pulse: got %b want 0", oDONE);
    else pass_cnt++;
  endtask

  task automatic test_stride();
    do_start(32'h10, 32'h20, 5, 0);
    collect(1000, 0, 100);
    build_model(32'h10, 32'h20, 5, 0, 0);
    total_cnt++;
    if (obs_addr.size() != exp_addr.size() || obs_timeout || obs_done != 1)
      $display("FAIL stride_len: got %0d beats done %0d want %0d beats done 1", obs_addr.size(), obs_done, exp_addr.size());
    else pass_cnt++;
    for (int k = 0; k < exp_addr.size() && k < obs_addr.size(); k++) begin
      total_cnt++;
      if (obs_addr[k] !== exp_addr[k] || obs_last[k] !== exp_last[k])
        $display("FAIL stride_beat%0d: got %h/%b want %h/%b", k, obs_addr[k], obs_last[k], exp_addr[k], exp_last[k]);
      else pass_cnt++;
    end
    do_start(32'h30, 32'h33, 0, 0);
    collect(1000, 0, 100);
    build_model(32'h30, 32'h33, 0, 0, 0);
    total_cnt++;
    if (obs_addr.size() != exp_addr.size() || obs_timeout)
      $display("FAIL step0_len: got %0d want %0d", obs_addr.size(), exp_addr.size());
    else pass_cnt++;
    for (int k = 0; k < exp_addr.size() && k < obs_addr.size(); k++) begin
      total_cnt++;
      if (obs_addr[k] !== exp_addr[k])
        $display("FAIL step0_beat%0d: got %h want %h", k, obs_addr[k], exp_addr[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    do_start(32'h100, 32'h11F, 3, 0);
    collect(1000, 1, 300);
    build_model(32'h100, 32'h11F, 3, 0, 0);
    total_cnt++;
    if (obs_addr.size() != exp_addr.size() || obs_timeout)
      $display("FAIL bp_len: got %0d want %0d", obs_addr.size(), exp_addr.size());
    else pass_cnt++;
    for (int k = 0; k < exp_addr.size() && k < obs_addr.size(); k++) begin
      total_cnt++;
      if (obs_addr[k] !== exp_addr[k] || obs_last[k] !== exp_last[k])
        $display("FAIL bp_beat%0d: got %h/%b want %h/%b", k, obs_addr[k], obs_last[k], exp_addr[k], exp_last[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (obs_unstable != 0) $display("FAIL bp_stable: got %0d changes while stalled want 0", obs_unstable);
    else pass_cnt++;
    total_cnt++;
    if (oCOUNT !== 23'(exp_len)) $display("FAIL bp_count: got %0d want %0d", oCOUNT, exp_len);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_start(4, 6, 1, 1);
    collect(12, 2, 300);
    build_model(4, 6, 1, 1, 12);
    total_cnt++;
    if (obs_addr.size() != 12 || obs_timeout) $display("FAIL wrap_len: got %0d want 12", obs_addr.size());
    else pass_cnt++;
    for (int k = 0; k < exp_addr.size() && k < obs_addr.size(); k++) begin
      total_cnt++;
      if (obs_addr[k] !== exp_addr[k] || obs_last[k] !== exp_last[k])
        $display("FAIL wrap_beat%0d: got %h/%b want %h/%b", k, obs_addr[k], obs_last[k], exp_addr[k], exp_last[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (obs_wraps != 4 || obs_done != 0) $display("FAIL wrap_pulses: got wraps %0d done %0d want 4/0", obs_wraps, obs_done);
    else pass_cnt++;
    total_cnt++;
    if (oVALID !== 1'b1 || oBUSY !== 1'b1) $display("FAIL wrap_running: got v%b b%b want v1 b1", oVALID, oBUSY);
    else pass_cnt++;
    do_stop();
    total_cnt++;
    if (oVALID !== 1'b0 || oBUSY !== 1'b0 || oDONE !== 1'b0)
      $display("FAIL wrap_stop: got v%b b%b d%b want 000", oVALID, oBUSY, oDONE);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    bit found = 1'b0;
    int dseen = 0;
    do_start(0, 20, 1, 0);
    iREADY = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (oADDRESS === 23'd3) begin
        found = 1'b1;
        break;
      end
      @(negedge iCLK);
    end
    total_cnt++;
    if (!found) $display("FAIL abort_reach3: got addr %h want 3 within 20 cycles", oADDRESS);
    else pass_cnt++;
    iSTOP  = 1'b1;
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTOP  = 1'b0;
    iSTART = 1'b0;
    total_cnt++;
    if (oVALID !== 1'b0 || oBUSY !== 1'b0 || oDONE !== 1'b0)
      $display("FAIL abort_idle: got v%b b%b d%b want 000", oVALID, oBUSY, oDONE);
    else pass_cnt++;
    total_cnt++;
    if (oADDRESS !== 23'd3 || oCOUNT !== 23'd3)
      $display("FAIL abort_hold: got a%h c%0d want a3 c3", oADDRESS, oCOUNT);
    else pass_cnt++;
    repeat (5) begin
      if (oDONE || oVALID) dseen++;
      @(negedge iCLK);
    end
    iREADY = 1'b0;
    total_cnt++;
    if (dseen != 0) $display("FAIL abort_quiet: got %0d active cycles want 0", dseen);
    else pass_cnt++;
  endtask

  task automatic test_edge();
    longint mx = (longint'(1) << WIDE) - 1;
    do_start(8, 2, 1, 0);
    collect(1000, 0, 50);
    total_cnt++;
    if (obs_addr.size() != 1 || obs_timeout || obs_done != 1)
      $display("FAIL rev_len: got %0d beats done %0d want 1/1", obs_addr.size(), obs_done);
    else pass_cnt++;
    total_cnt++;
    if (obs_addr.size() < 1 || obs_addr[0] !== 23'd8 || obs_last[0] !== 1'b1)
      $display("FAIL rev_beat: got %h/%b want 8/1", obs_addr.size() ? obs_addr[0] : 23'h0, obs_last.size() ? obs_last[0] : 1'b0);
    else pass_cnt++;
    // Collector returns in DONE, so this start is a restart from DONE.
    do_start(mx - 10, mx, 3, 0);
    collect(1000, 2, 100);
    build_model(mx - 10, mx, 3, 0, 0);
    total_cnt++;
    if (obs_addr.size() != exp_addr.size() || obs_timeout || obs_done != 1)
      $display("FAIL top_len: got %0d done %0d want %0d/1", obs_addr.size(), obs_done, exp_addr.size());
    else pass_cnt++;
    for (int k = 0; k < exp_addr.size() && k < obs_addr.size(); k++) begin
      total_cnt++;
      if (obs_addr[k] !== exp_addr[k] || obs_last[k] !== exp_last[k])
        $display("FAIL top_beat%0d: got %h/%b want %h/%b", k, obs_addr[k], obs_last[k], exp_addr[k], exp_last[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (oCOUNT !== 23'd4 || oADDRESS !== 23'h7FFFFE)
      $display("FAIL top_final: got c%0d a%h want c4 a7ffffe", oCOUNT, oADDRESS);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_start(0, 100, 1, 0);
    iREADY = 1'b1;
    repeat (4) @(negedge iCLK);
    #2;
    iRST_N = 1'b0;
    #1;
    total_cnt++;
    if ({oADDRESS, oCOUNT} !== '0) $display("FAIL areset_addr_count: got %h/%h want 0/0", oADDRESS, oCOUNT);
    else pass_cnt++;
    total_cnt++;
    if ({oVALID, oBUSY, oBURST_LAST, oWRAP_P, oDONE} !== 5'b0)
      $display("FAIL areset_flags: got %b want 00000", {oVALID, oBUSY, oBURST_LAST, oWRAP_P, oDONE});
    else pass_cnt++;
    iREADY = 1'b0;
    @(negedge iCLK);
    iRST_N = 1'b1;
    @(negedge iCLK);
    total_cnt++;
    if (oVALID !== 1'b0 || oDONE !== 1'b0) $display("FAIL areset_idle: got v%b d%b want 00", oVALID, oDONE);
    else pass_cnt++;
    do_start(5, 12, 2, 0);
    collect(1000, 2, 100);
    build_model(5, 12, 2, 0, 0);
    total_cnt++;
    if (obs_addr.size() != exp_addr.size() || obs_timeout || oCOUNT !== 23'(exp_len))
      $display("FAIL areset_restart: got %0d beats c%0d want %0d", obs_addr.size(), oCOUNT, exp_len);
    else pass_cnt++;
    for (int k = 0; k < exp_addr.size() && k < obs_addr.size(); k++) begin
      total_cnt++;
      if (obs_addr[k] !== exp_addr[k])
        $display("FAIL areset_beat%0d: got %h want %h", k, obs_addr[k], exp_addr[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      longint s, e;
      int st, n;
      bit w;
      s  = longint'($urandom_range(0, 300));
      e  = ($urandom_range(0, 4) == 0) ? (s >> 1) : s + longint'($urandom_range(0, 80));
      st = int'($urandom_range(0, 9));
      w  = 1'($urandom_range(0, 1));
      n  = w ? int'($urandom_range(5, 40)) : 1000;
      do_start(s, e, st, w);
      collect(n, 2, 2000);
      build_model(s, e, st, w, n);
      total_cnt++;
      if (obs_addr.size() != exp_addr.size() || obs_timeout)
        $display("FAIL rand%0d_len: got %0d want %0d", it, obs_addr.size(), exp_addr.size());
      else pass_cnt++;
      for (int k = 0; k < exp_addr.size() && k < obs_addr.size(); k++) begin
        total_cnt++;
        if (obs_addr[k] !== exp_addr[k] || obs_last[k] !== exp_last[k])
          $display("FAIL rand%0d_beat%0d: got %h/%b want %h/%b", it, k, obs_addr[k], obs_last[k], exp_addr[k], exp_last[k]);
        else pass_cnt++;
      end
      total_cnt++;
      if (obs_done != (w ? 0 : 1) || obs_wraps != (w ? n / exp_len : 0) || obs_unstable != 0)
        $display("FAIL rand%0d_pulses: got done %0d wraps %0d unstable %0d want %0d/%0d/0",
                 it, obs_done, obs_wraps, obs_unstable, w ? 0 : 1, w ? n / exp_len : 0);
      else pass_cnt++;
      if (w) do_stop();
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_stride();
    test_backpressure();
    test_wrap();
    test_abort();
    test_edge();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/burst_address_gen.md
Name: burst_address_gen

Overview:
- Parametrised successor to the free-running frame-buffer address counter.
- Produces a programmable address sequence from start to end with a configurable stride, using a valid/ready handshake toward the memory/SDRAM read port.
- Supports one-shot and continuous (wrap) modes, abort, burst-boundary marking and a completion pulse.
- Sits between the video/chunk controller (which issues start/stop) and the memory request port.

Parameters:
- WIDE, 23, address width in bits.
- STEP_W, 8, stride input width in bits.
- BURST_LEN, 8, beats per burst group; power of two, >= 2.

Ports:
- iCLK  input  1  clock; all logic on rising edge.
- iRST_N  input  1  reset.
- iSTART  input  1  one-cycle pulse; latches the configuration and begins a sequence.
- iSTOP  input  1  abort; returns the block to IDLE.
- iSTART_ADDR  input  WIDE  first address.
- iEND_ADDR  input  WIDE  inclusive upper bound.
- iSTEP  input  STEP_W  address increment; 0 is treated as 1.
- iWRAP  input  1  1 = continuous (wrap to start), 0 = one-shot.
- iREADY  input  1  consumer accepts oADDRESS this cycle.
- oADDRESS  output  WIDE  current address.
- oVALID  output  1  oADDRESS is valid.
- oBURST_LAST  output  1  current beat is the last of a BURST_LEN group, or the final address of the sequence.
- oWRAP_P  output  1  one-cycle pulse when the sequence wraps.
- oDONE  output  1  one-cycle pulse when a one-shot sequence completes.
- oBUSY  output  1  high in RUN.
- oCOUNT  output  WIDE  number of beats accepted since the last start (saturates at all-ones).

Behaviour:
- Reset: iRST_N asynchronous, active-low. All outputs and internal registers go to 0; state = IDLE.
- States are IDLE, RUN and DONE.
- IDLE/DONE + iSTART (iSTOP low):
  - Latch start, end, step (0 becomes 1) and wrap.
  - Next cycle: oADDRESS = start, oVALID = 1, oBUSY = 1, oCOUNT = 0, beat counter = 0, state = RUN.
  - Latency is one cycle from iSTART to first valid.
- Accept is oVALID & iREADY. oADDRESS and oVALID hold stable while iREADY is low.
- RUN, on accept:
  - Compute nxt = oADDRESS + step in WIDE+1 bits.
  - oCOUNT increments.
  - Beat counter increments modulo BURST_LEN.
- Last-address condition: nxt > end, or oADDRESS >= end. The second term handles start > end, which emits exactly one address.
- On accept with the last-address condition true:
  - Wrap mode: oADDRESS <= start, oWRAP_P = 1 for one cycle, beat counter <= 0, stay in RUN, oVALID remains 1.
  - One-shot mode: oVALID <= 0, oBUSY <= 0, oDONE = 1 for one cycle, state = DONE. oADDRESS holds the last address.
- On accept with the last-address condition false: oADDRESS <= nxt[WIDE-1:0].
- oBURST_LAST is combinational from registered state: (beat counter == BURST_LEN-1) | last-address condition.
- The end address is never exceeded. A non-aligned stride stops at the largest start + k*step <= end.
- iSTOP in any state, with priority over iSTART and accept:
  - Next cycle: IDLE, oVALID = 0, oBUSY = 0.
  - No oDONE; oADDRESS and oCOUNT hold.
- iSTART while in RUN is ignored. Restarting requires iSTOP first, or waiting for DONE.
- iSTART in DONE restarts immediately with the new configuration.
- The configuration inputs are sampled only on iSTART. Changes during RUN have no effect.
- Reset asserted mid-sequence: immediate return to the reset values; no pulses are emitted.

Decomposition:
- Shared package addr_gen_pkg holds:
  - state encoding constants ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2;
  - the default WIDE.
- One natural sub-module, addr_step_cmp:
  - combinational WIDE+1-bit adder plus comparator;
  - produces nxt and the last-address flag;
  - is reused by the planned write-side generator.
- The FSM, beat counter and count register stay in the top level.

Test Plan:
- One-shot: start = 0, end = 9, step = 1, iREADY held 1 -> addresses 0..9 on consecutive cycles; oBURST_LAST at 7 and 9; oDONE one cycle after accepting 9; oCOUNT = 10.
- Stride and bound: start = 0x10, end = 0x20, step = 5 -> 0x10, 0x15, 0x1A, 0x1F, then DONE (0x24 is never issued). Step = 0 must give a step of 1.
- Backpressure: iREADY toggles 1,0,0,1,... -> oADDRESS stable during low cycles; no addresses skipped or duplicated; final oCOUNT equals the number of addresses.
- Wrap: start = 4, end = 6, iWRAP = 1 -> 4,5,6,4,5,6...; oWRAP_P pulses once per 6->4 transition; oDONE is never asserted; oBURST_LAST on each 6.
- Abort and edge cases:
  - iSTOP at address 3 with iSTART asserted the same cycle -> IDLE, oVALID = 0, no oDONE.
  - start = 8, end = 2 -> single address 8, then oDONE.
  - end = 2^WIDE - 1 with step = 3 -> no wrap-around overflow.
- Async reset mid-RUN (iRST_N low between clock edges) -> all outputs 0 immediately. After release, iSTART begins a clean sequence.
